// File: rtl/debug_dump_ctrl_pkg.sv
// Shared definitions for the halt-time debug dump controller: FSM state
// encoding, byte-selector codes, the default frame header and frame sizing.
package debug_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5,
        ST_DONE    = 3'd6
    } dump_state_e;

    // Which byte of the frame is currently being presented to the UART.
    typedef enum logic [2:0] {
        SEL_HDR    = 3'd0,
        SEL_PC_HI  = 3'd1,
        SEL_PC_LO  = 3'd2,
        SEL_ACC_HI = 3'd3,
        SEL_ACC_LO = 3'd4,
        SEL_RAM_HI = 3'd5,
        SEL_RAM_LO = 3'd6
    } byte_sel_e;

    localparam logic [7:0]  DUMP_HEADER_DEFAULT = 8'hA5;
    // Header + PC (2 bytes) + ACC (2 bytes) precede the RAM words.
    localparam int unsigned FRAME_OVERHEAD      = 5;

    // Total number of bytes in one frame for a given dump size.
    function automatic int unsigned frame_len(input int unsigned words);
        return FRAME_OVERHEAD + 32'd2 * words;
    endfunction

endpackage

// File: rtl/debug_dump_ctrl_byte_sel.sv
// Combinational byte multiplexer: picks the frame byte named by sel_i from the
// header, the captured PC (zero-extended to 16 bits), the captured ACC and the
// most recently latched RAM word.
module dump_byte_sel
    import debug_dump_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 16,
    parameter int unsigned ADDR_LENGTH = 11,
    parameter logic [7:0]  HEADER      = DUMP_HEADER_DEFAULT
) (
    input  logic [2:0]             sel_i,
    input  logic [ADDR_LENGTH-1:0] pc_i,
    input  logic [DATA_LENGTH-1:0] acc_i,
    input  logic [DATA_LENGTH-1:0] ram_word_i,
    output logic [7:0]             byte_o
);

    logic [15:0] pc16_s;
    logic [15:0] acc16_s;
    logic [15:0] ram16_s;

    // Widen all sources to 16 bits, then select one byte of the frame.
    always_comb begin
        pc16_s  = 16'(pc_i);
        acc16_s = 16'(acc_i);
        ram16_s = 16'(ram_word_i);
        byte_o  = 8'h00;
        case (sel_i)
            SEL_HDR:    byte_o = HEADER;
            SEL_PC_HI:  byte_o = pc16_s[15:8];
            SEL_PC_LO:  byte_o = pc16_s[7:0];
            SEL_ACC_HI: byte_o = acc16_s[15:8];
            SEL_ACC_LO: byte_o = acc16_s[7:0];
            SEL_RAM_HI: byte_o = ram16_s[15:8];
            SEL_RAM_LO: byte_o = ram16_s[7:0];
            default:    byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/debug_dump_ctrl.sv
// Debug dump controller: when the CPU halts, streams one frame over a byte
// UART -- header, PC, ACC, then RAM[0..DUMP_WORDS-1] high byte first -- and
// then waits in DONE until halt is released so a held halt never re-triggers.
module debug_dump_ctrl
    import debug_dump_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 16,
    parameter int unsigned ADDR_LENGTH = 11,
    parameter int unsigned DUMP_WORDS  = 16,
    parameter logic [7:0]  HEADER      = DUMP_HEADER_DEFAULT
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_halt,
    input  logic [ADDR_LENGTH-1:0] i_pc,
    input  logic [DATA_LENGTH-1:0] i_acc,
    output logic [ADDR_LENGTH-1:0] o_ram_addr,
    output logic                   o_ram_rd,
    input  logic [DATA_LENGTH-1:0] i_ram_data,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    // One extra counter bit keeps a full-memory dump from wrapping to zero.
    localparam logic [ADDR_LENGTH:0] LAST_WORD = (ADDR_LENGTH + 1)'(DUMP_WORDS - 1);
    localparam logic [ADDR_LENGTH:0] WORD_ONE  = (ADDR_LENGTH + 1)'(1);

    dump_state_e            state_q,    state_d;
    byte_sel_e              sel_q,      sel_d;
    logic [ADDR_LENGTH:0]   word_q,     word_d;
    logic [ADDR_LENGTH-1:0] pc_q,       pc_d;
    logic [DATA_LENGTH-1:0] acc_q,      acc_d;
    logic [DATA_LENGTH-1:0] ram_word_q, ram_word_d;
    logic [7:0]             tx_data_q,  tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic [ADDR_LENGTH-1:0] ram_addr_q, ram_addr_d;
    logic                   ram_rd_q,   ram_rd_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic [7:0]             byte_s;

    dump_byte_sel #(
        .DATA_LENGTH (DATA_LENGTH),
        .ADDR_LENGTH (ADDR_LENGTH),
        .HEADER      (HEADER)
    ) u_byte_sel (
        .sel_i      (sel_q),
        .pc_i       (pc_q),
        .acc_i      (acc_q),
        .ram_word_i (ram_word_q),
        .byte_o     (byte_s)
    );

    // Next-state, counters and registered-output values for the dump FSM.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        word_d     = word_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        ram_word_d = ram_word_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_rd_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_halt) begin
                    pc_d    = i_pc;
                    acc_d   = i_acc;
                    word_d  = '0;
                    sel_d   = SEL_HDR;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                tx_data_d = byte_s;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                tx_data_d  = byte_s;
                tx_start_d = 1'b1;
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // A done pulse overlapping our own start pulse belongs to the
                // previous byte, so it is not accepted for the new one.
                if (i_tx_done && !tx_start_q) begin
                    case (sel_q)
                        SEL_HDR: begin
                            sel_d   = SEL_PC_HI;
                            state_d = ST_SEND;
                        end
                        SEL_PC_HI: begin
                            sel_d   = SEL_PC_LO;
                            state_d = ST_SEND;
                        end
                        SEL_PC_LO: begin
                            sel_d   = SEL_ACC_HI;
                            state_d = ST_SEND;
                        end
                        SEL_ACC_HI: begin
                            sel_d   = SEL_ACC_LO;
                            state_d = ST_SEND;
                        end
                        SEL_ACC_LO: begin
                            sel_d   = SEL_RAM_HI;
                            state_d = ST_RD;
                        end
                        SEL_RAM_HI: begin
                            sel_d   = SEL_RAM_LO;
                            state_d = ST_SEND;
                        end
                        SEL_RAM_LO: begin
                            if (word_q == LAST_WORD) begin
                                state_d = ST_DONE;
                            end else begin
                                word_d  = word_q + WORD_ONE;
                                sel_d   = SEL_RAM_HI;
                                state_d = ST_RD;
                            end
                        end
                        default: begin
                            state_d = ST_DONE;
                        end
                    endcase
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            ST_RD: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                ram_word_d = i_ram_data;
                state_d    = ST_SEND;
            end
            ST_DONE: begin
                if (!i_halt) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so they line up
        // with the state they describe.
        if (state_d == ST_RD) begin
            ram_rd_d   = 1'b1;
            ram_addr_d = word_d[ADDR_LENGTH-1:0];
        end else begin
            ram_rd_d   = 1'b0;
            ram_addr_d = ram_addr_q;
        end
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State, counters, captured CPU context and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_HDR;
            word_q     <= '0;
            pc_q       <= '0;
            acc_q      <= '0;
            ram_word_q <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            ram_addr_q <= '0;
            ram_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            word_q     <= word_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            ram_word_q <= ram_word_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            ram_addr_q <= ram_addr_d;
            ram_rd_q   <= ram_rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_ram_addr = ram_addr_q;
    assign o_ram_rd   = ram_rd_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Self-checking bench for debug_dump_ctrl: a small 2-word instance for the
// directed/randomised frame scenarios and a full-memory instance for the
// 2^ADDR_LENGTH-word dump. Expected frames come from a byte-list model.
module tb_debug_dump_ctrl;
    import debug_dump_ctrl_pkg::*;

    localparam int AW   = 11;
    localparam int DW   = 16;
    localparam int NW_A = 2;
    localparam int NW_B = 2048;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Small instance signals
    logic          halt_a, ram_rd_a, tx_start_a, tx_done_a, busy_a, done_a, md_a, sp_a;
    logic [AW-1:0] pc_a, ram_addr_a;
    logic [DW-1:0] acc_a, ram_data_a;
    logic [7:0]    tx_data_a;
    int            dly_a, cnt_a;
    // Full-memory instance signals
    logic          halt_b, ram_rd_b, tx_start_b, tx_done_b, busy_b, done_b, md_b;
    logic [AW-1:0] pc_b, ram_addr_b;
    logic [DW-1:0] acc_b, ram_data_b;
    logic [7:0]    tx_data_b;
    int            dly_b, cnt_b;

    logic [DW-1:0] mem_a [0:2047];
    logic [DW-1:0] mem_b [0:2047];

    logic [7:0]    q_a[$];
    int unsigned   sc_a[$];
    int unsigned   dc_a[$];
    logic [AW-1:0] ra_a[$];
    logic [7:0]    q_b[$];
    logic [AW-1:0] last_addr_b = '0;
    int            nrd_b = 0;
    logic [7:0]    exp_q[$];
    int            qa0, da0, ra0;

    assign tx_done_a = md_a | sp_a;
    assign tx_done_b = md_b;

    debug_dump_ctrl #(.DATA_LENGTH(DW), .ADDR_LENGTH(AW), .DUMP_WORDS(NW_A), .HEADER(8'hA5)) dut_a (
        .i_clock(clk), .i_reset(rst_n), .i_halt(halt_a), .i_pc(pc_a), .i_acc(acc_a),
        .o_ram_addr(ram_addr_a), .o_ram_rd(ram_rd_a), .i_ram_data(ram_data_a),
        .o_tx_start(tx_start_a), .o_tx_data(tx_data_a), .i_tx_done(tx_done_a),
        .o_busy(busy_a), .o_done(done_a));

    debug_dump_ctrl #(.DATA_LENGTH(DW), .ADDR_LENGTH(AW), .DUMP_WORDS(NW_B), .HEADER(8'hA5)) dut_b (
        .i_clock(clk), .i_reset(rst_n), .i_halt(halt_b), .i_pc(pc_b), .i_acc(acc_b),
        .o_ram_addr(ram_addr_b), .o_ram_rd(ram_rd_b), .i_ram_data(ram_data_b),
        .o_tx_start(tx_start_b), .o_tx_data(tx_data_b), .i_tx_done(tx_done_b),
        .o_busy(busy_b), .o_done(done_b));

    // Synchronous RAMs: data appears the cycle after the read request.
    always @(posedge clk) begin
        if (ram_rd_a) ram_data_a <= mem_a[ram_addr_a];
        if (ram_rd_b) ram_data_b <= mem_b[ram_addr_b];
    end

    // UART models: a done pulse some cycles after each start pulse.
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt_a <= 0; md_a <= 1'b0; cnt_b <= 0; md_b <= 1'b0;
        end else begin
            md_a <= 1'b0;
            md_b <= 1'b0;
            if (cnt_a > 1) cnt_a <= cnt_a - 1;
            else if (cnt_a == 1) begin cnt_a <= 0; md_a <= 1'b1; end
            else if (tx_start_a) cnt_a <= (dly_a > 0) ? dly_a : int'($urandom_range(4, 1));
            if (cnt_b > 1) cnt_b <= cnt_b - 1;
            else if (cnt_b == 1) begin cnt_b <= 0; md_b <= 1'b1; end
            else if (tx_start_b) cnt_b <= (dly_b > 0) ? dly_b : int'($urandom_range(4, 1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe outputs mid-cycle; the byte on the wire must stay put until done.
    always @(negedge clk) begin
        if (tx_start_a) begin q_a.push_back(tx_data_a); sc_a.push_back(cyc); end
        if (md_a) dc_a.push_back(cyc);
        if (ram_rd_a) ra_a.push_back(ram_addr_a);
        if (tx_start_b) q_b.push_back(tx_data_b);
        if (ram_rd_b) begin last_addr_b <= ram_addr_b; nrd_b <= nrd_b + 1; end
        if (md_a && busy_a && q_a.size() > 0) chk("tx_data_stable", tx_data_a, q_a[$]);
    end

    // Reference frame: header, PC, ACC, then every RAM word high byte first.
    task automatic make_exp(input logic [AW-1:0] pc, input logic [DW-1:0] acc,
                            input int nw, input bit use_b);
        logic [15:0] pc16;
        logic [15:0] w;
        pc16 = {5'd0, pc};
        exp_q.delete();
        exp_q.push_back(DUMP_HEADER_DEFAULT);
        exp_q.push_back(pc16[15:8]);
        exp_q.push_back(pc16[7:0]);
        exp_q.push_back(acc[15:8]);
        exp_q.push_back(acc[7:0]);
        for (int i = 0; i < nw; i++) begin
            w = use_b ? mem_b[i] : mem_a[i];
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic mark_a();
        qa0 = q_a.size(); da0 = dc_a.size(); ra0 = ra_a.size();
    endtask

    task automatic cmp_frame(input string tag, input bit use_b);
        int n, nbad;
        logic [7:0] got;
        nbad = 0;
        n = use_b ? q_b.size() : q_a.size() - qa0;
        chk({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            got = use_b ? q_b[i] : q_a[qa0 + i];
            if (exp_q.size() <= 16) chk($sformatf("%s_byte%0d", tag, i), got, exp_q[i]);
            else if (got !== exp_q[i]) nbad++;
        end
        if (exp_q.size() > 16) chk({tag, "_bad_bytes"}, nbad, 0);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return done_a;
            1: return done_b;
            2: return tx_start_a;
            3: return ram_rd_a;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait (at negedges) for a DUT output to go high.
    task automatic wait_sig(input int which, input int budget, input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (!sig(which) && i < budget) begin @(negedge clk); i++; end
        chk({tag, "_reached"}, sig(which), 1'b1);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while ((q_a.size() - qa0) < n && i < budget) begin @(negedge clk); i++; end
        chk({tag, "_reached"}, ((q_a.size() - qa0) >= n), 1'b1);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_tx_start"}, tx_start_a, 1'b0);
        chk({tag, "_tx_data"},  tx_data_a,  8'h00);
        chk({tag, "_ram_rd"},   ram_rd_a,   1'b0);
        chk({tag, "_ram_addr"}, ram_addr_a, 11'h000);
        chk({tag, "_busy"},     busy_a,     1'b0);
        chk({tag, "_done"},     done_a,     1'b0);
    endtask

    initial begin
        int unsigned h;
        logic [AW-1:0] pc_s;
        logic [DW-1:0] acc_s;
        int gap;

        rst_n = 1'b1; halt_a = 1'b0; halt_b = 1'b0; sp_a = 1'b0;
        pc_a = '0; acc_a = '0; pc_b = '0; acc_b = '0; dly_a = 0; dly_b = 1;
        for (int i = 0; i < 2048; i++) begin
            mem_a[i] = 16'($urandom);
            mem_b[i] = 16'(i);
        end
        #1 rst_n = 1'b0;
        #1;
        chk_reset_a("reset");
        chk("reset_b_busy", busy_b, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed two-word frame, UART done 10 cycles after each start.
        mem_a[0] = 16'h1234; mem_a[1] = 16'hABCD;
        pc_s = 11'h123; acc_s = 16'hBEEF; pc_a = pc_s; acc_a = acc_s; dly_a = 10;
        make_exp(pc_s, acc_s, NW_A, 1'b0);
        mark_a();
        h = cyc; halt_a = 1'b1;
        repeat (2) @(negedge clk);
        pc_a = 11'h7FF; acc_a = 16'h0000;   // late changes must not leak into the frame
        wait_sig(0, 500, "s1_done");
        cmp_frame("s1", 1'b0);
        chk("s1_first_latency", sc_a[qa0] - h, 3);
        // Start lands one clear cycle after the done cycle; three across a RAM read.
        for (int k = 1; k < 9; k++) begin
            gap = (k >= 5 && ((k - 5) % 2) == 0) ? 4 : 2;
            chk($sformatf("s1_gap%0d", k), sc_a[qa0 + k] - dc_a[da0 + k - 1], gap);
        end
        chk("s1_busy", busy_a, 1'b0);
        chk("s1_ram_addr_held", ram_addr_a, 11'h001);
        chk("s1_reads", ra_a.size() - ra0, 2);
        chk("s1_read0", ra_a[ra0], 11'h000);
        chk("s1_read1", ra_a[ra0 + 1], 11'h001);

        // Halt held after DONE: no restart; release then re-halt gives same frame.
        mark_a();
        repeat (100) @(negedge clk);
        chk("s2_no_restart", q_a.size() - qa0, 0);
        chk("s2_done_held", done_a, 1'b1);
        halt_a = 1'b0;
        @(negedge clk);
        chk("s2_idle_done", done_a, 1'b0);
        chk("s2_idle_busy", busy_a, 1'b0);
        pc_a = pc_s; acc_a = acc_s; dly_a = 0;
        halt_a = 1'b1;
        wait_sig(0, 500, "s2_done");
        cmp_frame("s2", 1'b0);
        halt_a = 1'b0;
        repeat (2) @(negedge clk);

        // Spurious done pulses: in IDLE, on the start-pulse cycle, in RD_WAIT.
        mem_a[0] = 16'($urandom); mem_a[1] = 16'($urandom);
        pc_a = 11'($urandom); acc_a = 16'($urandom);
        make_exp(pc_a, acc_a, NW_A, 1'b0);
        mark_a();
        sp_a = 1'b1; @(negedge clk); sp_a = 1'b0; @(negedge clk);
        chk("s3_idle_ignore", busy_a, 1'b0);
        halt_a = 1'b1;
        wait_sig(2, 50, "s3_first_start");
        sp_a = 1'b1; @(negedge clk); sp_a = 1'b0;
        for (int r = 0; r < 2; r++) begin
            wait_sig(3, 200, $sformatf("s3_read%0d", r));
            @(negedge clk);
            sp_a = 1'b1; @(negedge clk); sp_a = 1'b0;
        end
        wait_sig(0, 500, "s3_done");
        cmp_frame("s3", 1'b0);
        halt_a = 1'b0;
        repeat (2) @(negedge clk);

        // Halt dropped at byte 2: frame completes, DONE lasts one cycle.
        mem_a[0] = 16'($urandom); mem_a[1] = 16'($urandom);
        pc_a = 11'($urandom); acc_a = 16'($urandom);
        make_exp(pc_a, acc_a, NW_A, 1'b0);
        mark_a();
        halt_a = 1'b1;
        wait_bytes(2, 100, "s6_byte2");
        halt_a = 1'b0;
        wait_sig(0, 500, "s6_done");
        cmp_frame("s6", 1'b0);
        @(negedge clk);
        chk("s6_back_idle_done", done_a, 1'b0);
        chk("s6_back_idle_busy", busy_a, 1'b0);
        repeat (2) @(negedge clk);

        // Reset during byte 4, then a fresh frame with halt still high.
        pc_a = 11'($urandom); acc_a = 16'($urandom);
        make_exp(pc_a, acc_a, NW_A, 1'b0);
        mark_a();
        halt_a = 1'b1;
        wait_bytes(4, 100, "s4_byte4");
        #2 rst_n = 1'b0;
        #1;
        chk_reset_a("s4_async");
        repeat (2) @(negedge clk);
        mark_a();
        h = cyc; rst_n = 1'b1;
        wait_sig(0, 500, "s4_done");
        cmp_frame("s4", 1'b0);
        chk("s4_first_latency", sc_a[qa0] - h, 3);
        halt_a = 1'b0;
        repeat (2) @(negedge clk);

        // Full-memory dump on the large instance.
        pc_b = 11'($urandom); acc_b = 16'($urandom);
        make_exp(pc_b, acc_b, NW_B, 1'b1);
        halt_b = 1'b1;
        wait_sig(1, 40000, "s5_done");
        cmp_frame("s5", 1'b1);
        chk("s5_len_4101", q_b.size(), frame_len(NW_B));
        chk("s5_last_addr", last_addr_b, 11'h7FF);
        chk("s5_reads", nrd_b, NW_B);
        chk("s5_busy", busy_b, 1'b0);
        halt_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("s5_back_idle", done_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/debug_dump_ctrl.md
DEBUG_DUMP_CTRL -- requirements
Module: debug_dump_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_LENGTH, 16: CPU word width (ACC, RAM data).
- ADDR_LENGTH, 11: CPU address width (PC, RAM address).
- DUMP_WORDS, 16: RAM words dumped, range 1..2^ADDR_LENGTH.
- HEADER, 8'hA5: frame start byte.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clock, in, 1: single clock, rising edge.
- i_reset, in, 1: asynchronous, active-low reset.
- i_halt, in, 1: CPU halted (level).
- i_pc, in, ADDR_LENGTH: CPU program counter.
- i_acc, in, DATA_LENGTH: CPU accumulator.
- o_ram_addr, out, ADDR_LENGTH: data-RAM read address.
- o_ram_rd, out, 1: data-RAM read enable.
- i_ram_data, in, DATA_LENGTH: RAM read data, valid 1 cycle after o_ram_rd.
- o_tx_start, out, 1: UART start pulse.
- o_tx_data, out, 8: UART byte.
- i_tx_done, in, 1: UART byte-complete pulse.
- o_busy, out, 1: dump in progress.
- o_done, out, 1: dump complete.

Function
REQ-003 The block SHALL, after the CPU halts, transmit one frame over UART: HEADER, PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], then RAM[0..DUMP_WORDS-1], each word high byte first. Total 5+2*DUMP_WORDS bytes.
REQ-004 PC SHALL be zero-extended to 16 bits.
REQ-005 PC and ACC SHALL be captured on the IDLE->START transition and held for the whole frame.
REQ-006 The FSM SHALL have the states IDLE, START, RD, RD_WAIT, SEND, WAIT_TX and DONE.
REQ-007 IDLE SHALL move to START on the first clock edge at which i_halt=1.
REQ-008 START SHALL load the header byte and go to SEND.
REQ-009 SEND SHALL assert o_tx_start for exactly one cycle with o_tx_data valid, then go to WAIT_TX.
REQ-010 WAIT_TX SHALL hold o_tx_data stable until i_tx_done=1, then select the next byte.
REQ-011 On each RAM-word boundary the FSM SHALL go RD (o_ram_rd=1, o_ram_addr=word index) -> RD_WAIT (latch i_ram_data) -> SEND.
REQ-012 After the low byte of word DUMP_WORDS-1 completes, the FSM SHALL go to DONE.
REQ-013 DONE SHALL hold o_done=1 until i_halt=0, then return to IDLE. A still-asserted halt SHALL never start a second frame.
REQ-014 Latency: o_tx_start SHALL first pulse 3 cycles after the edge sampling i_halt=1.
REQ-015 Each subsequent start pulse SHALL follow i_tx_done by 1 cycle, or by 3 cycles across a RAM read.
REQ-016 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-017 i_tx_done coincident with the o_tx_start cycle SHALL NOT count for the new byte.
REQ-018 o_busy SHALL be 1 in every state except IDLE and DONE.
REQ-019 o_ram_rd SHALL be 1 only in RD.
REQ-020 o_ram_addr SHALL hold the last read address otherwise.
REQ-021 Word counter width SHALL be ADDR_LENGTH+1 so that DUMP_WORDS=2^ADDR_LENGTH terminates without wrap.
REQ-022 i_halt falling mid-frame SHALL NOT abort the frame.
REQ-023 The FSM SHALL have no timeout; it SHALL wait indefinitely for i_tx_done.

Reset
REQ-024 i_reset=0 SHALL immediately, without a clock, force: state IDLE; o_tx_start, o_ram_rd, o_busy and o_done 0; o_tx_data and o_ram_addr 0; counters and captured registers 0.
REQ-025 Reset mid-frame SHALL abandon the frame; no partial resume.
REQ-026 After reset release, the first edge with i_halt=1 SHALL start a fresh frame.

Structure
REQ-027 State encodings, the HEADER default and the frame-overhead constant (5) SHALL live in a shared package used by the block and its bench.
REQ-028 A sub-module dump_byte_sel (combinational byte mux from byte index, captured PC/ACC and latched RAM word) is natural. The FSM and counters SHALL stay in debug_dump_ctrl.

Verification
REQ-029 The bench SHALL cover these scenarios:
- DUMP_WORDS=2, PC=11'h123, ACC=16'hBEEF, RAM[0]=16'h1234, RAM[1]=16'hABCD, UART done 10 cycles after each start -> bytes A5 01 23 BE EF 12 34 AB CD, then o_done=1.
- Halt held high after DONE for 100 cycles -> no further o_tx_start; drop halt -> IDLE; raise halt again -> second identical frame.
- Spurious i_tx_done pulses in IDLE and in RD_WAIT -> byte sequence and count unchanged.
- Reset asserted during byte 4 -> all outputs 0 asynchronously; after release plus halt -> full frame starts at A5.
- DUMP_WORDS=2^ADDR_LENGTH, RAM[i]=i -> last word address 11'h7FF, frame length 4101 bytes, terminates.
- i_halt deasserted at byte 2 -> frame completes, then DONE->IDLE next cycle.
